// File: rtl/shadow_stack_ctrl.sv
// Shadow return-address stack: pushes call return addresses, pops them on
// returns and compares against the resolved return target. A mismatch parks
// the controller in a sticky CRASH state until software clears it.
module shadow_stack_ctrl #(
  parameter int DEPTH = 16,
  parameter int VLEN  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     call_valid_i,
  input  logic [VLEN-1:0]          call_addr_i,
  input  logic                     ret_valid_i,
  input  logic [VLEN-1:0]          ret_target_i,
  output logic                     ready_o,
  output logic                     chk_valid_o,
  output logic                     chk_mismatch_o,
  output logic                     crash_o,
  input  logic                     clear_i,
  output logic [$clog2(DEPTH):0]   depth_o,
  output logic [7:0]               ovf_cnt_o,
  output logic [7:0]               unf_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, CMP, CRASH} state_t;

  state_t          state, state_nxt;
  logic [VLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   top_ptr;   // next free slot; wraps circularly
  logic [PW-1:0]   top_idx;   // slot holding the current top entry
  logic [CW-1:0]   depth_q;
  logic [VLEN-1:0] exp_q;
  logic [VLEN-1:0] tgt_q;
  logic [7:0]      ovf_q;
  logic [7:0]      unf_q;

  logic call_acc, ret_acc, pop_ok, full, mismatch;

  assign call_acc = call_valid_i && (state == IDLE);
  assign ret_acc  = ret_valid_i  && (state == IDLE);
  assign pop_ok   = ret_acc && (depth_q != '0);
  assign full     = (depth_q == CW'(DEPTH));
  assign top_idx  = top_ptr - PW'(1);
  // Target bit 0 is cleared when latched, so the compare ignores it.
  assign mismatch = (tgt_q != exp_q);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop_ok) state_nxt = CMP;
      CMP:     state_nxt = mismatch ? CRASH : IDLE;
      CRASH:   if (clear_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ready_o        = 1'b0;
    chk_valid_o    = 1'b0;
    chk_mismatch_o = 1'b0;
    crash_o        = 1'b0;
    case (state)
      IDLE:    ready_o = 1'b1;
      CMP: begin
        chk_valid_o    = 1'b1;
        chk_mismatch_o = mismatch;
      end
      CRASH:   crash_o = 1'b1;
      default: ;
    endcase
  end

  // Stack pointer, occupancy and saturating event counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      top_ptr <= '0;
      depth_q <= '0;
      ovf_q   <= '0;
      unf_q   <= '0;
    end else if ((state == CRASH) && clear_i) begin
      top_ptr <= '0;
      depth_q <= '0;
    end else begin
      if (ret_acc && (depth_q == '0) && (unf_q != 8'hFF))
        unf_q <= unf_q + 8'd1;
      // Call+pop in one cycle replaces the top in place: pointer and depth hold.
      case ({call_acc, pop_ok})
        2'b10: begin
          top_ptr <= top_ptr + PW'(1);
          if (full) begin
            if (ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
          end else begin
            depth_q <= depth_q + CW'(1);
          end
        end
        2'b01: begin
          top_ptr <= top_idx;
          depth_q <= depth_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Pop capture: expected address and resolved target for the CMP cycle
  always_ff @(posedge clk_i) begin
    if (pop_ok) begin
      exp_q <= mem[top_idx];
      tgt_q <= ret_target_i & ~VLEN'(1);
    end
  end

  // Entry storage; a call alongside a pop overwrites the popped slot
  always_ff @(posedge clk_i) begin
    if (!rst_i && call_acc) begin
      if (pop_ok) mem[top_idx] <= call_addr_i;
      else        mem[top_ptr] <= call_addr_i;
    end
  end

  assign depth_o   = depth_q;
  assign ovf_cnt_o = ovf_q;
  assign unf_cnt_o = unf_q;

endmodule

// File: tb/tb_shadow_stack_ctrl.sv
// Bench for shadow_stack_ctrl: directed scenarios plus a randomized run
// checked against a queue-based reference model of the stack behaviour.
module tb_shadow_stack_ctrl;

  localparam int DEPTH = 16;
  localparam int VLEN  = 32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             call_valid_i = 1'b0;
  logic [VLEN-1:0]  call_addr_i = '0;
  logic             ret_valid_i = 1'b0;
  logic [VLEN-1:0]  ret_target_i = '0;
  logic             clear_i = 1'b0;
  logic             ready_o, chk_valid_o, chk_mismatch_o, crash_o;
  logic [4:0]       depth_o;
  logic [7:0]       ovf_cnt_o, unf_cnt_o;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_stk[$];
  int          m_ovf, m_unf;
  bit          m_cmp, m_mis, m_crash;

  shadow_stack_ctrl #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .call_valid_i(call_valid_i), .call_addr_i(call_addr_i),
    .ret_valid_i(ret_valid_i), .ret_target_i(ret_target_i),
    .ready_o(ready_o), .chk_valid_o(chk_valid_o),
    .chk_mismatch_o(chk_mismatch_o), .crash_o(crash_o),
    .clear_i(clear_i), .depth_o(depth_o),
    .ovf_cnt_o(ovf_cnt_o), .unf_cnt_o(unf_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Apply one cycle of inputs, advance the model at the edge, settle 1ns after.
  task automatic drive(input bit call, input logic [31:0] ca, input bit ret,
                       input logic [31:0] rt, input bit clr, input bit rst);
    logic [31:0] e;
    call_valid_i = call; call_addr_i = ca;
    ret_valid_i  = ret;  ret_target_i = rt;
    clear_i = clr; rst_i = rst;
    @(posedge clk_i);
    if (rst) begin
      m_stk.delete(); m_ovf = 0; m_unf = 0; m_cmp = 0; m_mis = 0; m_crash = 0;
    end else if (m_crash) begin
      if (clr) begin m_crash = 0; m_stk.delete(); end
    end else if (m_cmp) begin
      m_cmp = 0; m_crash = m_mis; m_mis = 0;
    end else begin
      if (ret) begin
        if (m_stk.size() > 0) begin
          e = m_stk.pop_back();
          m_mis = ((rt & ~32'h1) != e);
          m_cmp = 1;
        end else if (m_unf < 255) m_unf++;
      end
      if (call) begin
        if (m_stk.size() == DEPTH) begin
          void'(m_stk.pop_front());
          if (m_ovf < 255) m_ovf++;
        end
        m_stk.push_back(ca);
      end
    end
    #1;
    call_valid_i = 1'b0; ret_valid_i = 1'b0; clear_i = 1'b0; rst_i = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 1);
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", ready_o); end
    total++; if (depth_o !== 5'd0) begin bad++; $display("FAIL reset_depth got=%0d want=0", depth_o); end
    total++; if ({chk_valid_o, chk_mismatch_o, crash_o} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {chk_valid_o, chk_mismatch_o, crash_o}); end
    total++; if ({ovf_cnt_o, unf_cnt_o} !== 16'h0) begin bad++; $display("FAIL reset_cnts got=%h want=0000", {ovf_cnt_o, unf_cnt_o}); end
  endtask

  task automatic test_match();
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 32'h80000104, 0, 0, 0, 0);
    total++; if (depth_o !== 5'd1) begin bad++; $display("FAIL match_push_depth got=%0d want=1", depth_o); end
    drive(0, 0, 1, 32'h80000104, 0, 0);
    total++; if ({chk_valid_o, chk_mismatch_o} !== 2'b10) begin bad++; $display("FAIL match_chk got=%b want=10", {chk_valid_o, chk_mismatch_o}); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL match_cmp_ready got=%0b want=0", ready_o); end
    drive(0, 0, 0, 0, 0, 0);
    total++; if ({ready_o, crash_o, chk_valid_o} !== 3'b100 || depth_o !== 5'd0) begin bad++; $display("FAIL match_idle got rdy/crash/chk=%b depth=%0d want 100 depth=0", {ready_o, crash_o, chk_valid_o}, depth_o); end
  endtask

  task automatic test_mismatch();
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 32'h80000104, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h80000200, 0, 0);
    total++; if ({chk_valid_o, chk_mismatch_o, crash_o} !== 3'b110) begin bad++; $display("FAIL mis_cmp got=%b want=110", {chk_valid_o, chk_mismatch_o, crash_o}); end
    drive(0, 0, 0, 0, 0, 0);
    total++; if ({crash_o, ready_o, chk_valid_o, chk_mismatch_o} !== 4'b1000) begin bad++; $display("FAIL mis_crash got=%b want=1000", {crash_o, ready_o, chk_valid_o, chk_mismatch_o}); end
    drive(1, 32'h1234, 0, 0, 0, 0);
    total++; if (crash_o !== 1'b1) begin bad++; $display("FAIL mis_sticky got=%0b want=1", crash_o); end
    drive(0, 0, 0, 0, 1, 0);
    total++; if ({ready_o, crash_o} !== 2'b10 || depth_o !== 5'd0) begin bad++; $display("FAIL mis_clear got rdy/crash=%b depth=%0d want 10 depth=0", {ready_o, crash_o}, depth_o); end
  endtask

  task automatic test_overflow();
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) drive(1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0);
    total++; if (depth_o !== 5'd16 || ovf_cnt_o !== 8'd1) begin bad++; $display("FAIL ovf_full got depth=%0d ovf=%0d want 16/1", depth_o, ovf_cnt_o); end
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 32'h1040 - 32'(4 * i), 0, 0);
      total++; if ({chk_valid_o, chk_mismatch_o} !== 2'b10) begin bad++; $display("FAIL ovf_pop%0d got=%b want=10", i, {chk_valid_o, chk_mismatch_o}); end
      drive(0, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 1, 32'h1000, 0, 0);
    total++; if ({ready_o, chk_valid_o} !== 2'b10 || unf_cnt_o !== 8'd1 || depth_o !== 5'd0) begin bad++; $display("FAIL ovf_underflow got rdy/chk=%b unf=%0d depth=%0d want 10/1/0", {ready_o, chk_valid_o}, unf_cnt_o, depth_o); end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 32'hA0, 0, 0, 0, 0);
    drive(1, 32'hB0, 1, 32'hA0, 0, 0);
    total++; if ({chk_valid_o, chk_mismatch_o} !== 2'b10 || depth_o !== 5'd1) begin bad++; $display("FAIL b2b_cmp got=%b depth=%0d want 10 depth=1", {chk_valid_o, chk_mismatch_o}, depth_o); end
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'hB0, 0, 0);
    total++; if ({chk_valid_o, chk_mismatch_o} !== 2'b10 || depth_o !== 5'd0) begin bad++; $display("FAIL b2b_top got=%b depth=%0d want 10 depth=0", {chk_valid_o, chk_mismatch_o}, depth_o); end
    drive(0, 0, 0, 0, 0, 0);
    // both events on an empty stack: push plus underflow, no check
    drive(1, 32'hC0, 1, 32'hC0, 0, 0);
    total++; if ({ready_o, chk_valid_o} !== 2'b10 || depth_o !== 5'd1 || unf_cnt_o !== 8'd1) begin bad++; $display("FAIL b2b_empty got rdy/chk=%b depth=%0d unf=%0d want 10/1/1", {ready_o, chk_valid_o}, depth_o, unf_cnt_o); end
  endtask

  task automatic test_reset_priority();
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 32'h4, 0, 0);           // underflow so counters are nonzero
    drive(1, 32'h40, 0, 0, 0, 0);
    drive(1, 32'h44, 1, 32'h44, 0, 0);     // into CMP
    drive(0, 0, 1, 32'h40, 0, 1);          // reset while in CMP
    total++; if ({ready_o, chk_valid_o, chk_mismatch_o, crash_o} !== 4'b1000 || depth_o !== 5'd0 || unf_cnt_o !== 8'd0) begin bad++; $display("FAIL rst_cmp got flags=%b depth=%0d unf=%0d want 1000/0/0", {ready_o, chk_valid_o, chk_mismatch_o, crash_o}, depth_o, unf_cnt_o); end
    drive(0, 0, 1, 32'h4, 0, 0);
    drive(1, 32'h10, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h20, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    total++; if (crash_o !== 1'b1) begin bad++; $display("FAIL rst_pre_crash got=%0b want=1", crash_o); end
    drive(1, 32'h50, 0, 0, 1, 1);          // reset while in CRASH
    total++; if ({ready_o, chk_valid_o, chk_mismatch_o, crash_o} !== 4'b1000 || depth_o !== 5'd0 || {ovf_cnt_o, unf_cnt_o} !== 16'h0) begin bad++; $display("FAIL rst_crash got flags=%b depth=%0d cnts=%h want 1000/0/0000", {ready_o, chk_valid_o, chk_mismatch_o, crash_o}, depth_o, {ovf_cnt_o, unf_cnt_o}); end
  endtask

  task automatic test_hold();
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 32'h300, 0, 0, 0, 0);
    drive(1, 32'h304, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h304, 0, 0);
    // requester holds the next return while the block is in CMP
    drive(0, 0, 1, 32'h300, 0, 0);
    total++; if ({ready_o, chk_valid_o} !== 2'b10 || depth_o !== 5'd1) begin bad++; $display("FAIL hold_blocked got rdy/chk=%b depth=%0d want 10/1", {ready_o, chk_valid_o}, depth_o); end
    drive(0, 0, 1, 32'h300, 0, 0);
    total++; if ({chk_valid_o, chk_mismatch_o} !== 2'b10 || depth_o !== 5'd0) begin bad++; $display("FAIL hold_accept got=%b depth=%0d want 10/0", {chk_valid_o, chk_mismatch_o}, depth_o); end
    drive(0, 0, 0, 0, 0, 0);
    total++; if (ready_o !== 1'b1 || unf_cnt_o !== 8'd0 || depth_o !== 5'd0) begin bad++; $display("FAIL hold_once got rdy=%0b unf=%0d depth=%0d want 1/0/0", ready_o, unf_cnt_o, depth_o); end
  endtask

  task automatic test_random();
    bit call, ret, clr, rst;
    logic [31:0] ca, rt;
    drive(0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 1500; n++) begin
      call = ($urandom_range(0, 9) < 6);
      ret  = ($urandom_range(0, 9) < 4);
      clr  = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      ca   = $urandom & ~32'h1;
      if (m_stk.size() > 0 && $urandom_range(0, 4) != 0)
        rt = m_stk[$] | 32'($urandom_range(0, 1));
      else
        rt = $urandom;
      drive(call, ca, ret, rt, clr, rst);
      total++; if (ready_o !== (!m_cmp && !m_crash)) begin bad++; $display("FAIL rnd_ready n=%0d got=%0b want=%0b", n, ready_o, !m_cmp && !m_crash); end
      total++; if (chk_valid_o !== m_cmp) begin bad++; $display("FAIL rnd_chk_valid n=%0d got=%0b want=%0b", n, chk_valid_o, m_cmp); end
      total++; if (chk_mismatch_o !== (m_cmp && m_mis)) begin bad++; $display("FAIL rnd_mismatch n=%0d got=%0b want=%0b", n, chk_mismatch_o, m_cmp && m_mis); end
      total++; if (crash_o !== m_crash) begin bad++; $display("FAIL rnd_crash n=%0d got=%0b want=%0b", n, crash_o, m_crash); end
      total++; if (depth_o !== 5'(m_stk.size())) begin bad++; $display("FAIL rnd_depth n=%0d got=%0d want=%0d", n, depth_o, m_stk.size()); end
      total++; if (ovf_cnt_o !== 8'(m_ovf) || unf_cnt_o !== 8'(m_unf)) begin bad++; $display("FAIL rnd_cnts n=%0d got ovf=%0d unf=%0d want %0d/%0d", n, ovf_cnt_o, unf_cnt_o, m_ovf, m_unf); end
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_overflow();
    test_back_to_back();
    test_reset_priority();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shadow_stack_ctrl.md
SHADOW_STACK_CTRL -- requirements
Module: shadow_stack_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of return-address entries (power of two, 2..64).
REQ-002 The block SHALL have parameter VLEN, default 32, meaning the address width.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1, the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port call_valid_i, input, 1, a resolved call (JAL/JALR with rd=x1) is offered.
REQ-006 The block SHALL have port call_addr_i, input, VLEN, the return address (next_pc) of that call.
REQ-007 The block SHALL have port ret_valid_i, input, 1, a resolved return (JALR, rd=x0, rs1=x1) is offered.
REQ-008 The block SHALL have port ret_target_i, input, VLEN, the resolved target of that return.
REQ-009 The block SHALL have port ready_o, output, 1, events are accepted this cycle.
REQ-010 The block SHALL have port chk_valid_o, output, 1, a return comparison result is presented this cycle.
REQ-011 The block SHALL have port chk_mismatch_o, output, 1, qualifies chk_valid_o: the target differed from the stacked address.
REQ-012 The block SHALL have port crash_o, output, 1, sticky violation flag.
REQ-013 The block SHALL have port clear_i, input, 1, software acknowledge that leaves CRASH.
REQ-014 The block SHALL have port depth_o, output, $clog2(DEPTH)+1, current entry count.
REQ-015 The block SHALL have port ovf_cnt_o, output, 8, saturating count of overwritten entries.
REQ-016 The block SHALL have port unf_cnt_o, output, 8, saturating count of returns seen on an empty stack.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, CMP and CRASH.
REQ-018 ready_o SHALL be 1 in IDLE only; an event is accepted when its valid and ready_o are both high; requesters hold valid and data until accepted.
REQ-019 An accepted call SHALL push call_addr_i at the top; depth_o increments by 1.
REQ-020 A push at depth DEPTH SHALL overwrite the oldest entry (circular wrap); depth_o stays DEPTH and ovf_cnt_o increments, saturating at 255.
REQ-021 An accepted return with depth_o>0 SHALL pop the top into an expected register, latch ret_target_i, decrement depth_o and move to CMP.
REQ-022 An accepted return with depth_o=0 SHALL perform no check and stay in IDLE; unf_cnt_o increments, saturating at 255.
REQ-023 In CMP, chk_valid_o SHALL be 1 and chk_mismatch_o SHALL be the full VLEN-bit inequality of the latched target and the expected address (target bit 0 ignored); this is 1 cycle after acceptance.
REQ-024 From CMP the FSM SHALL go to IDLE on a match and to CRASH on a mismatch.
REQ-025 crash_o SHALL equal (state==CRASH), so it first rises 2 cycles after the mismatching return is accepted.
REQ-026 CRASH SHALL hold until clear_i=1, then go to IDLE with the stack emptied (depth_o=0); counters are kept.
REQ-027 A call and a return accepted in the same IDLE cycle SHALL compare against the pre-push top; the net effect is that the top is replaced by call_addr_i, depth_o is unchanged, and the FSM goes to CMP.
REQ-028 A call plus a return on an empty stack in the same cycle SHALL push, count an underflow, and stay in IDLE.
REQ-029 clear_i SHALL be ignored outside CRASH.
REQ-030 chk_valid_o and chk_mismatch_o SHALL be 0 in IDLE and CRASH.

Reset
REQ-031 rst_i=1 at a clock edge SHALL force IDLE, depth_o=0, ovf_cnt_o=0, unf_cnt_o=0, crash_o=0, chk_valid_o=0 and chk_mismatch_o=0, with ready_o=1 in the following cycle.
REQ-032 rst_i SHALL take priority over every event, including an event in CMP or CRASH; entry contents need not be cleared.

Verification
REQ-033 The bench SHALL cover: call 0x80000104, then return target 0x80000104 -> chk_valid_o=1 and chk_mismatch_o=0 one cycle later, then IDLE, depth_o=0, crash_o stays 0.
REQ-034 The bench SHALL cover: call 0x80000104, then return target 0x80000200 -> chk_mismatch_o=1 in CMP, crash_o=1 from the next cycle, ready_o=0; clear_i=1 -> IDLE with depth_o=0.
REQ-035 The bench SHALL cover: 17 calls 0x1000..0x1040 (step 4) with DEPTH=16 -> depth_o=16 and ovf_cnt_o=1; then 16 matching returns pass, popping 0x1040 down to 0x1004, and a 17th return gives unf_cnt_o=1 with no check.
REQ-036 The bench SHALL cover: with stack [0xA0], a simultaneous call 0xB0 and return 0xA0 -> match, depth_o=1, top=0xB0; then return 0xB0 -> match.
REQ-037 The bench SHALL cover: rst_i asserted in CMP and in CRASH -> next cycle IDLE, depth_o=0, all outputs and counters 0.
REQ-038 The bench SHALL cover: ret_valid_i held while in CMP -> not accepted until ready_o=1, then accepted exactly once.
